// File: rtl/ir_key_event.sv
// ir_key_event: front end between the NEC IR decoder and the password logic.
// It turns each rising edge of the decoder's data-ready level into at most one
// validated and classified key event on a valid/ready handshake. A held key
// that auto-repeats within the holdoff window is dropped instead of re-emitted.
module ir_key_event #(
  parameter logic [15:0]  CUSTOM_CODE    = 16'h6B86,
  parameter bit           CHECK_CUSTOM   = 1'b1,
  parameter int unsigned  HOLDOFF_CYCLES = 12_500_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        ir_ready,
  input  logic [31:0] ir_data,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [7:0]  key_code,
  output logic [2:0]  key_class,
  output logic [3:0]  key_digit,
  output logic [7:0]  err_count,
  output logic        overflow,
  output logic        busy
);

  // The holdoff register only ever holds values up to HOLDOFF_CYCLES-1.
  localparam int HW = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HOLDOFF_RELOAD = HW'(HOLDOFF_CYCLES - 1);

  localparam logic [2:0] CLS_DIGIT   = 3'b001;
  localparam logic [2:0] CLS_ENTER   = 3'b010;
  localparam logic [2:0] CLS_CLEAR   = 3'b011;
  localparam logic [2:0] CLS_CONFIRM = 3'b100;
  localparam logic [2:0] CLS_OTHER   = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_rdy_d;
  logic [31:0]    r_cap;
  logic [HW-1:0]  r_holdoff;
  logic [7:0]     r_last_key;
  logic           r_last_valid;
  logic [7:0]     r_key_code;
  logic [2:0]     r_key_class;
  logic [3:0]     r_key_digit;
  logic [7:0]     r_err_count;
  logic           r_overflow;

  logic           w_rise;
  logic [7:0]     w_key;
  logic           w_cmpl_ok;
  logic           w_cust_ok;
  logic           w_frame_ok;
  logic           w_repeat;
  logic           w_capture;
  logic           w_reject;
  logic           w_reload;
  logic           w_load;

  function automatic logic [2:0] classify(input logic [7:0] k);
    logic [2:0] c;
    if (k <= 8'h09) begin
      c = CLS_DIGIT;
    end else begin
      case (k)
        8'h1A:   c = CLS_ENTER;
        8'h1E:   c = CLS_CLEAR;
        8'h16:   c = CLS_CONFIRM;
        default: c = CLS_OTHER;
      endcase
    end
    return c;
  endfunction

  function automatic logic [3:0] digit_of(input logic [7:0] k);
    return (k <= 8'h09) ? k[3:0] : 4'd0;
  endfunction

  assign w_rise     = ir_ready & ~r_rdy_d;
  assign w_key      = r_cap[23:16];
  assign w_cmpl_ok  = (r_cap[31:24] == ~r_cap[23:16]);
  assign w_cust_ok  = !CHECK_CUSTOM || (r_cap[15:0] == CUSTOM_CODE);
  assign w_frame_ok = w_cmpl_ok & w_cust_ok;
  // A repeat is the same key as the last accepted one while holdoff is still running.
  assign w_repeat   = r_last_valid && (w_key == r_last_key) && (r_holdoff != '0);

  // Next-state and per-cycle action decode.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_reject  = 1'b0;
    w_reload  = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_capture = 1'b1;
          w_next    = S_CHECK;
        end
      end
      S_CHECK: begin
        w_next = S_IDLE;
        if (!w_frame_ok) begin
          w_reject = 1'b1;
        end else begin
          // Both a dropped repeat and an accepted key restart the holdoff window,
          // so a key held down indefinitely keeps being suppressed.
          w_reload = 1'b1;
          if (!w_repeat) begin
            w_load = 1'b1;
            w_next = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (key_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and ready-strobe delay for edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rdy_d <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy_d <= ir_ready;
    end
  end

  // Frame capture on an accepted rising edge; only read during CHECK.
  always_ff @(posedge CLOCK_50) begin
    if (w_capture) r_cap <= ir_data;
  end

  // Holdoff countdown with reload taking priority over the decrement.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_holdoff <= '0;
    end else if (w_reload) begin
      r_holdoff <= HOLDOFF_RELOAD;
    end else if (r_holdoff != '0) begin
      r_holdoff <= r_holdoff - HW'(1);
    end
  end

  // Remember the last accepted key for repeat suppression.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_last_valid <= 1'b0;
      r_last_key   <= 8'h00;
    end else if (w_load) begin
      r_last_valid <= 1'b1;
      r_last_key   <= w_key;
    end
  end

  // Event output registers, loaded once per accepted key and held through EMIT.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_key_code  <= 8'h00;
      r_key_class <= 3'b000;
      r_key_digit <= 4'h0;
    end else if (w_load) begin
      r_key_code  <= w_key;
      r_key_class <= classify(w_key);
      r_key_digit <= digit_of(w_key);
    end
  end

  // Rejected-frame counter, saturating at its maximum.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_err_count <= 8'h00;
    end else if (w_reject && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  // Sticky flag for frames that arrive while a previous one is still in flight.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_rise && (r_state != S_IDLE)) begin
      r_overflow <= 1'b1;
    end
  end

  assign key_valid = (r_state == S_EMIT);
  assign busy      = (r_state != S_IDLE);
  assign key_code  = r_key_code;
  assign key_class = r_key_class;
  assign key_digit = r_key_digit;
  assign err_count = r_err_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ir_key_event.sv
// Testbench for ir_key_event: directed scenarios plus randomized traffic,
// checked every cycle against a timestamp-based behavioural model.
module tb_ir_key_event;

  localparam int H = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_nc = 1'b1;
  logic        ir_ready = 1'b0;
  logic [31:0] ir_data = 32'h0;
  logic        key_ready = 1'b0;

  logic        key_valid, overflow, busy;
  logic [7:0]  key_code, err_count;
  logic [2:0]  key_class;
  logic [3:0]  key_digit;

  logic        nc_valid, nc_overflow, nc_busy;
  logic [7:0]  nc_code, nc_err;
  logic [2:0]  nc_class;
  logic [3:0]  nc_digit;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ir_key_event #(.CUSTOM_CODE(16'h6B86), .CHECK_CUSTOM(1'b1), .HOLDOFF_CYCLES(H)) dut (
    .CLOCK_50(clk), .reset(rst), .ir_ready(ir_ready), .ir_data(ir_data),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_class(key_class), .key_digit(key_digit), .err_count(err_count),
    .overflow(overflow), .busy(busy));

  // Second instance that ignores the custom code; held in reset except for its own test.
  ir_key_event #(.CUSTOM_CODE(16'h6B86), .CHECK_CUSTOM(1'b0), .HOLDOFF_CYCLES(H)) dut_nc (
    .CLOCK_50(clk), .reset(rst_nc), .ir_ready(ir_ready), .ir_data(ir_data),
    .key_valid(nc_valid), .key_ready(key_ready), .key_code(nc_code),
    .key_class(nc_class), .key_digit(nc_digit), .err_count(nc_err),
    .overflow(nc_overflow), .busy(nc_busy));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [2:0] ref_class(input logic [7:0] k);
    if (k < 8'd10)  return 3'b001;
    if (k == 8'h1A) return 3'b010;
    if (k == 8'h1E) return 3'b011;
    if (k == 8'h16) return 3'b100;
    return 3'b101;
  endfunction

  int          cyc = 0;
  bit          m_rdy_d = 0, m_check = 0, m_emit = 0, m_last_valid = 0, m_ovf = 0;
  logic [31:0] m_cap = 0;
  logic [7:0]  m_last_key = 0, m_code = 0;
  logic [2:0]  m_class = 0;
  logic [3:0]  m_digit = 0;
  int          m_err = 0;
  int          m_reload = 0;

  // A frame is a repeat while fewer than H edges have passed since the last
  // holdoff restart, expressed directly with edge timestamps.
  always @(posedge clk) begin : model_b
    bit rise;
    logic [7:0] k;
    cyc++;
    rise = ir_ready && !m_rdy_d;
    if (rst) begin
      m_rdy_d = 0; m_check = 0; m_emit = 0; m_last_valid = 0;
      m_err = 0; m_ovf = 0; m_code = 0; m_class = 0; m_digit = 0;
    end else begin
      m_rdy_d = ir_ready;
      if (m_emit) begin
        if (rise) m_ovf = 1;
        if (key_ready) m_emit = 0;
      end else if (m_check) begin
        if (rise) m_ovf = 1;
        m_check = 0;
        k = m_cap[23:16];
        if (m_cap[31:24] != ~k || m_cap[15:0] != 16'h6B86) begin
          m_err = (m_err >= 255) ? 255 : m_err + 1;
        end else if (m_last_valid && k == m_last_key && (cyc - m_reload) < H) begin
          m_reload = cyc;
        end else begin
          m_code = k; m_class = ref_class(k);
          m_digit = (k < 8'd10) ? k[3:0] : 4'd0;
          m_last_key = k; m_last_valid = 1; m_reload = cyc; m_emit = 1;
        end
      end else if (rise) begin
        m_cap = ir_data;
        m_check = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", key_valid, m_emit);
      check("busy", busy, m_emit | m_check);
      check("err_count", err_count, m_err);
      check("overflow", overflow, m_ovf);
      if (m_emit) begin
        check("key_code", key_code, m_code);
        check("key_class", key_class, m_class);
        check("key_digit", key_digit, m_digit);
      end
    end
  end

  // Event counters: one event per rising edge of key_valid.
  int         ev_cnt = 0, nc_ev = 0;
  logic [7:0] ev_code = 0;
  logic [2:0] ev_class = 0;
  bit         prev_v = 0, nc_prev = 0;
  always @(negedge clk) begin
    if (key_valid === 1'b1 && !prev_v) begin
      ev_cnt++; ev_code = key_code; ev_class = key_class;
    end
    prev_v = (key_valid === 1'b1);
    if (nc_valid === 1'b1 && !nc_prev) nc_ev++;
    nc_prev = (nc_valid === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [31:0] d);
    ir_data = d;
    ir_ready = 1'b1;
    tick(1);
    ir_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_frame();
    logic [7:0] keys [6] = '{8'h05, 8'h1A, 8'h1E, 8'h16, 8'h03, 8'h40};
    logic [7:0] k, inv;
    logic [15:0] cc;
    k = keys[$urandom_range(0, 5)];
    inv = ($urandom_range(0, 9) < 8) ? ~k : 8'($urandom_range(0, 255));
    cc = ($urandom_range(0, 9) < 9) ? 16'h6B86 : 16'h1234;
    return {inv, k, cc};
  endfunction

  int e0;

  initial begin
    tick(2);
    rst = 1'b0;
    check("reset_valid", key_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err_count, 0);
    check("reset_ovf", overflow, 0);
    check("reset_code", {key_code, key_class, key_digit}, 0);
    chk_en = 1'b1;

    // Valid digit, two-clock latency, one-cycle valid with ready high.
    key_ready = 1'b1;
    pulse(32'hFA05_6B86);
    check("t1_busy_check", busy, 1);
    check("t1_not_yet", key_valid, 0);
    tick(1);
    check("t1_valid", key_valid, 1);
    check("t1_code", key_code, 8'h05);
    check("t1_class", key_class, 3'b001);
    check("t1_digit", key_digit, 4'd5);
    tick(1);
    check("t1_valid_drop", key_valid, 0);

    // Rejects, and the same frames with the custom-code check disabled.
    rst_nc = 1'b0;
    tick(1);
    e0 = ev_cnt;
    pulse(32'h0005_6B86);
    tick(2);
    pulse(32'hFA05_1234);
    tick(3);
    check("t2_err", err_count, 2);
    check("t2_no_event", ev_cnt, e0);
    check("t2_nc_err", nc_err, 1);
    check("t2_nc_event", nc_ev, 1);
    rst_nc = 1'b1;

    // Repeat suppression with a 100-cycle holdoff.
    e0 = ev_cnt;
    pulse(32'hE51A_6B86);
    tick(48);
    pulse(32'hE51A_6B86);
    tick(3);
    check("t3_one_event", ev_cnt, e0 + 1);
    check("t3_class_enter", ev_class, 3'b010);
    tick(116);
    pulse(32'hE51A_6B86);
    tick(3);
    check("t3_after_holdoff", ev_cnt, e0 + 2);
    tick(6);
    pulse(32'hE11E_6B86);
    tick(3);
    check("t3_other_key", ev_cnt, e0 + 3);
    check("t3_class_clear", ev_class, 3'b011);

    // Backpressure with a second frame arriving during EMIT.
    key_ready = 1'b0;
    e0 = ev_cnt;
    pulse(32'hE916_6B86);
    tick(1);
    check("t4_valid", key_valid, 1);
    check("t4_ovf_before", overflow, 0);
    pulse(32'hFC03_6B86);
    tick(2);
    check("t4_still_valid", key_valid, 1);
    check("t4_code", key_code, 8'h16);
    check("t4_class", key_class, 3'b100);
    check("t4_ovf", overflow, 1);
    key_ready = 1'b1;
    tick(1);
    check("t4_valid_drop", key_valid, 0);
    tick(4);
    check("t4_one_event", ev_cnt, e0 + 1);
    check("t4_idle", busy, 0);

    // Reset during EMIT, then the same key is accepted at once.
    key_ready = 1'b0;
    tick(110);
    pulse(32'hE916_6B86);
    tick(2);
    check("t5_emit", key_valid, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_rst_valid", key_valid, 0);
    check("t5_rst_outs", {key_code, key_class, key_digit}, 0);
    check("t5_rst_err", err_count, 0);
    check("t5_rst_ovf", overflow, 0);
    check("t5_rst_busy", busy, 0);
    key_ready = 1'b1;
    e0 = ev_cnt;
    pulse(32'hE916_6B86);
    tick(3);
    check("t5_reaccept", ev_cnt, e0 + 1);
    check("t5_code", ev_code, 8'h16);

    // Error counter saturation.
    e0 = ev_cnt;
    for (int i = 0; i < 300; i++) begin
      pulse(32'hFF05_6B86);
      tick(1);
      if (i == 254) check("t6_reach_255", err_count, 255);
    end
    tick(2);
    check("t6_saturated", err_count, 255);
    check("t6_no_event", ev_cnt, e0);

    // Randomized traffic.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ir_ready = !ir_ready;
        if (ir_ready) ir_data = rand_frame();
      end
      key_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(3);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
